nic_fifo: RTL

- Parametrised successor to the single-entry NIC between the PE pipeline and the ring router.
- Replaces the one-packet input/output channel buffers with DEPTH-entry FIFOs and exposes occupancy and overflow status to the PE.
- Performs polarity-gated injection on the packet virtual-channel bit.
- Drop-in for the NIC in the NIC+PE wrapper; the pipeline accesses it through a 2-bit register address.

---
 rtl/nic_fifo_if.sv | 28 ++
 rtl/nic_fifo.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/nic_fifo_if.sv
// PE register bus and ring-router link of the NIC, bundled for nic_fifo.
// The slave modport is the NIC's view; the master modport is the PE/router side.
interface nic_fifo_if #(
    parameter int DATA_W = 64
);
    logic              nicEn;
    logic              nicWrEN;
    logic [1:0]        addr;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_out;
    logic              net_si;
    logic              net_ri;
    logic [DATA_W-1:0] net_di;
    logic              net_so;
    logic              net_ro;
    logic [DATA_W-1:0] net_do;
    logic              net_polarity;

    modport slave (
        input  nicEn, nicWrEN, addr, d_in, net_si, net_di, net_ro, net_polarity,
        output d_out, net_ri, net_so, net_do
    );

    modport master (
        output nicEn, nicWrEN, addr, d_in, net_si, net_di, net_ro, net_polarity,
        input  d_out, net_ri, net_so, net_do
    );
endinterface

// File: rtl/nic_fifo.sv
// NIC between PE pipeline and ring router: DEPTH-entry input/output FIFOs,
// PE-visible occupancy/overflow status, and polarity-gated packet injection.
module nic_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int VC_BIT = 63
) (
    input  logic       clk,
    input  logic       reset,
    nic_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [DATA_W-1:0] in_mem_q  [DEPTH];
    logic [DATA_W-1:0] out_mem_q [DEPTH];
    logic [AW-1:0]     in_wp_q, in_rp_q, out_wp_q, out_rp_q;
    logic [CW-1:0]     in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic              ovf_q, ovf_d;
    logic              net_so_q, net_so_d;
    logic [DATA_W-1:0] net_do_q, net_do_d;
    logic [DATA_W-1:0] out_head_s, d_out_s;
    logic              pe_rd_s, pe_wr_s;
    logic              in_full_s, out_full_s, in_nonempty_s, out_nonempty_s;
    logic              in_push_s, in_pop_s, out_push_s, out_pop_s;

    // Access decode, handshakes and next-state for counts, overflow and link outputs
    always_comb begin
        pe_rd_s        = bus.nicEn & ~bus.nicWrEN;
        pe_wr_s        = bus.nicEn &  bus.nicWrEN;
        in_full_s      = (in_cnt_q  == FULL_C);
        out_full_s     = (out_cnt_q == FULL_C);
        in_nonempty_s  = (in_cnt_q  != {CW{1'b0}});
        out_nonempty_s = (out_cnt_q != {CW{1'b0}});
        out_head_s     = out_mem_q[out_rp_q];

        in_push_s  = bus.net_si & ~in_full_s;
        in_pop_s   = pe_rd_s & (bus.addr == 2'b00) & in_nonempty_s;
        // A blocked head stalls the whole output FIFO; a send frees a slot for a same-edge write.
        out_pop_s  = out_nonempty_s & bus.net_ro & (out_head_s[VC_BIT] == bus.net_polarity);
        out_push_s = pe_wr_s & (bus.addr == 2'b10) & (~out_full_s | out_pop_s);

        ovf_d = ovf_q;
        if (pe_wr_s && (bus.addr == 2'b10) && out_full_s && !out_pop_s) begin
            ovf_d = 1'b1;
        end else if (pe_rd_s && (bus.addr == 2'b11)) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        case ({in_push_s, in_pop_s})
            2'b10:   in_cnt_d = in_cnt_q + CW'(1);
            2'b01:   in_cnt_d = in_cnt_q - CW'(1);
            default: in_cnt_d = in_cnt_q;
        endcase

        case ({out_push_s, out_pop_s})
            2'b10:   out_cnt_d = out_cnt_q + CW'(1);
            2'b01:   out_cnt_d = out_cnt_q - CW'(1);
            default: out_cnt_d = out_cnt_q;
        endcase

        if (out_pop_s) begin
            net_so_d = 1'b1;
            net_do_d = out_head_s;
        end else begin
            net_so_d = 1'b0;
            net_do_d = net_do_q;
        end
    end

    // PE read data mux
    always_comb begin
        d_out_s = {DATA_W{1'b0}};
        if (pe_rd_s) begin
            case (bus.addr)
                2'b00: begin
                    if (in_nonempty_s) begin
                        d_out_s = in_mem_q[in_rp_q];
                    end else begin
                        d_out_s = {DATA_W{1'b0}};
                    end
                end
                2'b01: begin
                    d_out_s[8 +: CW] = in_cnt_q;
                    d_out_s[0]       = in_nonempty_s;
                end
                2'b11: begin
                    d_out_s[8 +: CW] = out_cnt_q;
                    d_out_s[1]       = ovf_q;
                    d_out_s[0]       = out_full_s;
                end
                default: d_out_s = {DATA_W{1'b0}};
            endcase
        end else begin
            d_out_s = {DATA_W{1'b0}};
        end
    end

    // FIFO storage, pointers, counts and registered link outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                in_mem_q[i]  <= {DATA_W{1'b0}};
                out_mem_q[i] <= {DATA_W{1'b0}};
            end
            in_wp_q   <= {AW{1'b0}};
            in_rp_q   <= {AW{1'b0}};
            out_wp_q  <= {AW{1'b0}};
            out_rp_q  <= {AW{1'b0}};
            in_cnt_q  <= {CW{1'b0}};
            out_cnt_q <= {CW{1'b0}};
            ovf_q     <= 1'b0;
            net_so_q  <= 1'b0;
            net_do_q  <= {DATA_W{1'b0}};
        end else begin
            if (in_push_s) begin
                in_mem_q[in_wp_q] <= bus.net_di;
                in_wp_q           <= in_wp_q + AW'(1);
            end
            if (in_pop_s) begin
                in_rp_q <= in_rp_q + AW'(1);
            end
            if (out_push_s) begin
                out_mem_q[out_wp_q] <= bus.d_in;
                out_wp_q            <= out_wp_q + AW'(1);
            end
            if (out_pop_s) begin
                out_rp_q <= out_rp_q + AW'(1);
            end
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            ovf_q     <= ovf_d;
            net_so_q  <= net_so_d;
            net_do_q  <= net_do_d;
        end
    end

    assign bus.d_out  = d_out_s;
    assign bus.net_ri = ~in_full_s;
    assign bus.net_so = net_so_q;
    assign bus.net_do = net_do_q;
endmodule
